// File: rtl/wrapper_pkg.sv
// Shared types and constants for the airframe-side UART command wrapper.
package wrapper_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_HIGH, RX_LOW} rx_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  localparam logic [7:0] POS_ACK = 8'hA5;
  localparam int FRAME_BYTES = 3;

endpackage

// File: rtl/uart_cmd_wrapper_uart.sv
// 8N1 UART transceiver: one start bit, eight data bits LSB first, one stop bit.
module uart_cmd_wrapper_uart #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  input  logic       clr_rx_rdy,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  output logic       tx_done
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] B_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] B_HALF = BW'(BAUD_DIV / 2);

  logic [9:0]    tx_shift_reg;
  logic [3:0]    tx_bits_reg;
  logic [BW-1:0] tx_baud_reg;
  logic          tx_busy_reg;

  logic          rx_meta_reg, rx_s_reg, rx_busy_reg;
  logic [8:0]    rx_shift_reg;
  logic [3:0]    rx_bits_reg;
  logic [BW-1:0] rx_baud_reg;

  assign TX = tx_shift_reg[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_shift_reg <= '1;
      tx_bits_reg  <= '0;
      tx_baud_reg  <= '0;
      tx_busy_reg  <= 1'b0;
      tx_done      <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (trmt && !tx_busy_reg) begin
        tx_shift_reg <= {1'b1, tx_data, 1'b0};
        tx_bits_reg  <= '0;
        tx_baud_reg  <= '0;
        tx_busy_reg  <= 1'b1;
      end else if (tx_busy_reg) begin
        if (tx_baud_reg == B_LAST) begin
          tx_baud_reg  <= '0;
          tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
          if (tx_bits_reg == 4'd9) begin
            tx_busy_reg <= 1'b0;
            tx_done     <= 1'b1;
          end else begin
            tx_bits_reg <= tx_bits_reg + 4'd1;
          end
        end else begin
          tx_baud_reg <= tx_baud_reg + 1'b1;
        end
      end
    end
  end

  // Samples start bit and data bits mid-bit; rx_rdy rises at the middle of the stop bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_reg  <= 1'b1;
      rx_s_reg     <= 1'b1;
      rx_busy_reg  <= 1'b0;
      rx_shift_reg <= '0;
      rx_bits_reg  <= '0;
      rx_baud_reg  <= '0;
      rx_data      <= '0;
      rx_rdy       <= 1'b0;
    end else begin
      rx_meta_reg <= RX;
      rx_s_reg    <= rx_meta_reg;
      if (clr_rx_rdy) rx_rdy <= 1'b0;
      if (!rx_busy_reg) begin
        if (!rx_s_reg) begin
          rx_busy_reg <= 1'b1;
          rx_baud_reg <= B_HALF;
          rx_bits_reg <= '0;
        end
      end else if (rx_baud_reg == B_LAST) begin
        rx_baud_reg <= '0;
        if (rx_bits_reg == 4'd9) begin
          rx_busy_reg <= 1'b0;
          rx_rdy      <= 1'b1;
          rx_data     <= rx_shift_reg[8:1];
        end else begin
          rx_shift_reg <= {rx_s_reg, rx_shift_reg[8:1]};
          rx_bits_reg  <= rx_bits_reg + 4'd1;
        end
      end else begin
        rx_baud_reg <= rx_baud_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Assembles 3-byte command frames from the UART with an inter-byte timeout,
// and sends single-byte responses back on TX.
module uart_cmd_wrapper
  import wrapper_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int BAUD_DIV       = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        frame_err,
  output logic        overrun
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [7:0]    rx_data, tx_data_reg, stg_cmd_reg, stg_hi_reg;
  logic          rx_rdy, clr_rx_rdy, tx_done, trmt_reg;
  logic [TW-1:0] timer_reg;
  rx_state_t     rx_state_reg, rx_state_next;
  tx_state_t     tx_state_reg, tx_state_next;
  logic          timeout, complete, tx_accept, tx_finish;

  uart_cmd_wrapper_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy),
    .tx_data(tx_data_reg), .trmt(trmt_reg), .tx_done(tx_done)
  );

  assign clr_rx_rdy = rx_rdy;

  always_comb begin
    rx_state_next = rx_state_reg;
    complete      = 1'b0;
    // A byte arriving on the timeout cycle still counts.
    timeout       = (rx_state_reg != RX_IDLE) && (timer_reg == T_LAST) && !rx_rdy;
    case (rx_state_reg)
      RX_IDLE: if (rx_rdy) rx_state_next = RX_HIGH;
      RX_HIGH: begin
        if (rx_rdy)       rx_state_next = RX_LOW;
        else if (timeout) rx_state_next = RX_IDLE;
      end
      RX_LOW: begin
        if (rx_rdy) begin
          rx_state_next = RX_IDLE;
          complete      = 1'b1;
        end else if (timeout) begin
          rx_state_next = RX_IDLE;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_accept     = 1'b0;
    tx_finish     = 1'b0;
    case (tx_state_reg)
      TX_IDLE: if (send_resp) begin
        tx_accept     = 1'b1;
        tx_state_next = TX_BUSY;
      end
      TX_BUSY: if (tx_done) begin
        tx_finish     = 1'b1;
        tx_state_next = TX_IDLE;
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_reg <= RX_IDLE;
      tx_state_reg <= TX_IDLE;
    end else begin
      rx_state_reg <= rx_state_next;
      tx_state_reg <= tx_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_reg   <= '0;
      stg_cmd_reg <= '0;
      stg_hi_reg  <= '0;
      cmd         <= '0;
      data        <= '0;
      cmd_rdy     <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
      trmt_reg    <= 1'b0;
      tx_data_reg <= '0;
      resp_sent   <= 1'b0;
    end else begin
      if (rx_rdy || rx_state_reg == RX_IDLE) timer_reg <= '0;
      else if (timer_reg != T_LAST)          timer_reg <= timer_reg + 1'b1;
      if (rx_state_reg == RX_IDLE && rx_rdy) stg_cmd_reg <= rx_data;
      if (rx_state_reg == RX_HIGH && rx_rdy) stg_hi_reg  <= rx_data;
      if (complete) begin
        cmd  <= stg_cmd_reg;
        data <= {stg_hi_reg, rx_data};
      end
      if (complete)         cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy) cmd_rdy <= 1'b0;
      frame_err <= timeout;
      overrun   <= complete && cmd_rdy && !clr_cmd_rdy;
      trmt_reg  <= tx_accept;
      if (tx_accept) tx_data_reg <= resp;
      resp_sent <= tx_finish;
    end
  end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Scoreboard bench: serial frames in, decoded frames and TX bytes checked against queues.
module tb_uart_cmd_wrapper;
  localparam int BAUD = 4;
  localparam int TMO  = 64;

  logic        clk = 1'b0, rst_n = 1'b0, RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0, send_resp = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        TX, cmd_rdy, resp_sent, frame_err, overrun;
  logic [7:0]  cmd;
  logic [15:0] data;

  typedef struct {logic [7:0] c; logic [15:0] d;} frame_t;
  frame_t     exp_q[$];
  logic [7:0] tx_exp[$];

  int errors = 0, checks = 0;
  int ncyc = 0, rdy_cyc = -100;
  int resp_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, drop_cnt = 0, tx_cnt = 0;
  logic cmd_rdy_q = 1'b0, watch_rdy = 1'b0;

  uart_cmd_wrapper #(.TIMEOUT_CYCLES(TMO), .BAUD_DIV(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .data(data),
    .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .resp(resp),
    .send_resp(send_resp), .resp_sent(resp_sent), .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Frame scoreboard and pulse counters, sampled on the falling edge.
  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      cmd_rdy_q = 1'b0;
    end else begin
      if (dut.rx_rdy) rdy_cyc = ncyc;
      if ((cmd_rdy && !cmd_rdy_q) || overrun) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame: got cmd=%h data=%h, required no frame", cmd, data);
        end else begin
          frame_t f;
          f = exp_q.pop_front();
          if (cmd !== f.c || data !== f.d) begin
            errors++;
            $display("FAIL frame: got cmd=%h data=%h, required cmd=%h data=%h", cmd, data, f.c, f.d);
          end else $display("frame ok: cmd=%h data=%h", cmd, data);
        end
        checks++;
        if (ncyc !== rdy_cyc + 1) begin
          errors++;
          $display("FAIL frame_latency: got %0d cycles after rx_rdy, required 1", ncyc - rdy_cyc);
        end
      end
      if (resp_sent) resp_cnt++;
      if (frame_err) ferr_cnt++;
      if (overrun)   ovr_cnt++;
      if (watch_rdy && !cmd_rdy) drop_cnt++;
      cmd_rdy_q = cmd_rdy;
    end
  end

  // TX decoder: checks every transmitted byte against the expected queue.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n && TX === 1'b0) begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          b[i] = TX;
        end
        repeat (BAUD) @(negedge clk);
        tx_cnt++;
        checks++;
        if (TX !== 1'b1) begin
          errors++;
          $display("FAIL tx_stop: got %b, required 1", TX);
        end
        checks++;
        if (tx_exp.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tx: got byte %h, required none", b);
        end else begin
          logic [7:0] e;
          e = tx_exp.pop_front();
          if (b !== e) begin
            errors++;
            $display("FAIL tx_byte: got %h, required %h", b, e);
          end else $display("tx byte ok: %h", b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = bits[i];
      repeat (BAUD) tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l);
    send_byte(c);
    send_byte(h);
    send_byte(l);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic send_response(input logic [7:0] b);
    resp = b;
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    resp = 8'h00;
  endtask

  task automatic wait_rdy(input string name);
    int n = 0;
    while (!cmd_rdy && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (!cmd_rdy) begin
      errors++;
      $display("FAIL %s_timeout: got cmd_rdy=0, required 1", name);
    end
  endtask

  task automatic wait_resp(input int target, input string name);
    int n = 0;
    while (resp_cnt < target && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (resp_cnt < target) begin
      errors++;
      $display("FAIL %s_resp_timeout: got resp_sent count %0d, required %0d", name, resp_cnt, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({cmd, data, cmd_rdy, resp_sent, frame_err, overrun, TX} !== {24'h0, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL reset: got cmd=%h data=%h rdy=%b rs=%b fe=%b ov=%b tx=%b, required 0/0/0/0/0/0/1",
               cmd, data, cmd_rdy, resp_sent, frame_err, overrun, TX);
    end else $display("reset ok");
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_basic_frame();
    exp_q.push_back('{8'h02, 16'h1234});
    send_frame(8'h02, 8'h12, 8'h34);
    wait_rdy("basic");
    repeat (5) tick();
    checks++;
    if (cmd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL basic_hold: got cmd_rdy=%b, required 1", cmd_rdy);
    end
    pulse_clr();
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL basic_clr: got cmd_rdy=%b, required 0", cmd_rdy);
    end else $display("clr ok");
  endtask

  task automatic test_timeout();
    int f0 = ferr_cnt;
    send_byte(8'h05);
    send_byte(8'hAB);
    repeat (200) tick();
    checks++;
    if (ferr_cnt !== f0 + 1 || cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err: got frame_err count %0d rdy=%b, required %0d rdy=0", ferr_cnt - f0, cmd_rdy, 1);
    end else $display("timeout frame_err ok");
    exp_q.push_back('{8'h06, 16'h0001});
    send_frame(8'h06, 8'h00, 8'h01);
    wait_rdy("timeout");
    checks++;
    if (ferr_cnt !== f0 + 1) begin
      errors++;
      $display("FAIL timeout_extra_err: got %0d frame_err pulses, required 1", ferr_cnt - f0);
    end
    pulse_clr();
  endtask

  task automatic test_overrun();
    int o0 = ovr_cnt;
    exp_q.push_back('{8'h01, 16'h1122});
    send_frame(8'h01, 8'h11, 8'h22);
    wait_rdy("overrun_first");
    watch_rdy = 1'b1;
    exp_q.push_back('{8'h03, 16'h3344});
    send_frame(8'h03, 8'h33, 8'h44);
    repeat (20) tick();
    watch_rdy = 1'b0;
    checks++;
    if (ovr_cnt !== o0 + 1) begin
      errors++;
      $display("FAIL overrun_count: got %0d pulses, required 1", ovr_cnt - o0);
    end
    checks++;
    if (drop_cnt !== 0 || cmd !== 8'h03 || data !== 16'h3344) begin
      errors++;
      $display("FAIL overrun_state: got drops=%0d cmd=%h data=%h, required 0/03/3344", drop_cnt, cmd, data);
    end else $display("overrun ok");
    pulse_clr();
  endtask

  task automatic test_response();
    int r0 = resp_cnt;
    int t0 = tx_cnt;
    tx_exp.push_back(8'hA5);
    send_response(8'hA5);
    repeat (10) tick();
    send_response(8'h3C);
    wait_resp(r0 + 1, "resp");
    repeat (80) tick();
    checks++;
    if (resp_cnt !== r0 + 1 || tx_cnt !== t0 + 1) begin
      errors++;
      $display("FAIL resp_single: got %0d resp_sent / %0d bytes, required 1 / 1", resp_cnt - r0, tx_cnt - t0);
    end else $display("response ok");
  endtask

  task automatic test_full_duplex();
    int r0 = resp_cnt;
    exp_q.push_back('{8'h04, 16'hFFFE});
    tx_exp.push_back(8'hA5);
    fork
      send_frame(8'h04, 8'hFF, 8'hFE);
      begin
        repeat (7) tick();
        send_response(8'hA5);
      end
    join
    wait_rdy("duplex");
    wait_resp(r0 + 1, "duplex");
    repeat (20) tick();
    checks++;
    if (data !== 16'hFFFE || resp_cnt !== r0 + 1) begin
      errors++;
      $display("FAIL duplex: got data=%h resp_sent=%0d, required FFFE / 1", data, resp_cnt - r0);
    end else $display("full duplex ok");
  endtask

  task automatic test_reset_mid_frame();
    int f0 = ferr_cnt;
    send_byte(8'h09);
    send_byte(8'h55);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({cmd, data, cmd_rdy, resp_sent, frame_err, overrun} !== 28'h0) begin
      errors++;
      $display("FAIL midreset: got cmd=%h data=%h rdy=%b, required all zero", cmd, data, cmd_rdy);
    end else $display("mid-frame reset ok");
    repeat (150) tick();
    checks++;
    if (ferr_cnt !== f0 || cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_err: got %0d frame_err rdy=%b, required 0 rdy=0", ferr_cnt - f0, cmd_rdy);
    end
    exp_q.push_back('{8'h07, 16'h0010});
    send_frame(8'h07, 8'h00, 8'h10);
    wait_rdy("midreset");
    pulse_clr();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_timeout();
    test_overrun();
    test_response();
    test_full_duplex();
    test_reset_mid_frame();
    repeat (20) tick();
    checks++;
    if (exp_q.size() != 0 || tx_exp.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d frames / %0d bytes pending, required 0 / 0", exp_q.size(), tx_exp.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_wrapper.md
Name: uart_cmd_wrapper

Overview:
- Airframe-side counterpart of the remote command transmitter.
- Receives 3-byte command frames over serial (cmd byte, data high byte, data low byte) and presents them as cmd[7:0] and data[15:0] with a cmd_rdy flag to the command processor.
- Transmits the 1-byte response (e.g. positive ack) back on TX.
- Adds an inter-byte timeout so a truncated frame cannot desynchronise later frames.

Parameters:
- TIMEOUT_CYCLES, 100000: clk cycles allowed between bytes of one frame before the partial frame is discarded. Must be ≥2. Benches override to a small value.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- RX  input  1  serial data from remote
- TX  output  1  serial data to remote
- cmd  output  8  command byte of last complete frame
- data  output  16  {byte2, byte3} of last complete frame
- cmd_rdy  output  1  complete frame available
- clr_cmd_rdy  input  1  consumer acknowledges frame
- resp  input  8  response byte to send
- send_resp  input  1  pulse: transmit resp
- resp_sent  output  1  1-cycle pulse when response transmission completes
- frame_err  output  1  1-cycle pulse when a partial frame is dropped on timeout
- overrun  output  1  1-cycle pulse when a frame completes while cmd_rdy is already high

Behaviour:
- Reset (rst_n low at posedge clk):
  - cmd=0x00, data=0x0000.
  - cmd_rdy, resp_sent, frame_err, overrun all 0.
  - State IDLE, timer 0, TX idle high.
- Receive path uses the existing UART instance.
  - clr_rx_rdy is asserted combinationally in every cycle rx_rdy=1 is consumed.
  - Each byte is therefore consumed exactly once.
- Staging registers stg_cmd and stg_hi hold bytes 1 and 2.
  - cmd/data outputs change only on frame completion.
  - They stay stable while cmd_rdy is high until the next complete frame.
- Receive FSM:
  - IDLE: rx_rdy -> stg_cmd<=rx_data, timer<=0, go HIGH.
  - HIGH: rx_rdy -> stg_hi<=rx_data, timer<=0, go LOW. Timeout -> go IDLE, pulse frame_err.
  - LOW: rx_rdy -> cmd<=stg_cmd, data<={stg_hi, rx_data}, set cmd_rdy, go IDLE. Timeout -> go IDLE, pulse frame_err.
- Latency: cmd_rdy rises the cycle after rx_rdy of byte 3 is sampled.
- Timer:
  - Counts only in HIGH and LOW, saturating.
  - Timeout fires when timer==TIMEOUT_CYCLES-1 and rx_rdy=0.
  - rx_rdy in the same cycle as the timeout wins: the byte is accepted and no frame_err is raised.
  - Timer width is $clog2(TIMEOUT_CYCLES).
- cmd_rdy:
  - Set on frame completion; cleared by clr_cmd_rdy.
  - Completion and clr_cmd_rdy in the same cycle -> cmd_rdy stays 1, because the new frame wins.
  - Completion while cmd_rdy=1 and no clr -> outputs overwritten, cmd_rdy stays 1, overrun pulses.
- Transmit path:
  - IDLE_TX: send_resp -> tx_data<=resp (registered), trmt pulses 1 cycle, go BUSY.
  - BUSY: tx_done -> resp_sent pulses 1 cycle, go IDLE_TX.
  - send_resp while BUSY is ignored; no queueing.
  - resp is sampled only on the accepted send_resp cycle.
- Receive and transmit FSMs are independent. Full-duplex operation is legal.
- Reset mid-frame: the partial frame is lost and no frame_err is raised.
- Reset mid-transmit: TX returns high immediately (UART reset) and no resp_sent is raised.

Decomposition:
- Shared package wrapper_pkg holds:
  - rx_state_t {RX_IDLE, RX_HIGH, RX_LOW}
  - tx_state_t {TX_IDLE, TX_BUSY}
  - POS_ACK = 8'hA5
  - FRAME_BYTES = 3
- The only sub-module is the existing UART transceiver. No new sub-module; the timer stays inline.

Test Plan:
- Frame 0x02,0x12,0x34 sent at full baud -> cmd=0x02, data=0x1234, cmd_rdy 1 cycle after third rx_rdy; cmd_rdy drops the cycle after clr_cmd_rdy pulse.
- TIMEOUT_CYCLES=64. Send 0x05,0xAB, then idle for 200 cycles, then frame 0x06,0x00,0x01 -> one frame_err pulse; cmd_rdy stays 0 until the second frame; then cmd=0x06, data=0x0001.
- Frame 0x01,0x11,0x22, no clr; then frame 0x03,0x33,0x44 -> overrun pulses once, cmd=0x03, data=0x3344, cmd_rdy=1 throughout.
- send_resp with resp=0xA5 -> TX carries 0xA5 (start, LSB first, stop), resp_sent single pulse. A second send_resp mid-transmission produces no extra byte.
- Full duplex: send_resp 0xA5 while receiving 0x04,0xFF,0xFE -> both complete; data=0xFFFE and resp_sent both observed.
- rst_n low for 1 cycle after byte 2 of a frame -> all outputs 0, no frame_err. A following full frame 0x07,0x00,0x10 decodes correctly.
